// File: rtl/btn_move_ctrl.sv
// Debounces four raw push buttons into single-direction moves offered on a valid/ready handshake.
// Latency: a clean press raises move_valid after edge DEBOUNCE_CYCLES+3 (2 sync flops + IDLE + debounce count).
// Backpressure: move_valid and move_dir hold in ISSUE until move_ready; buttons are ignored meanwhile.
module btn_move_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_L,
    input  logic        btn_R,
    input  logic        btn_U,
    input  logic        btn_D,
    input  logic        move_ready,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    output logic [15:0] move_count,
    output logic        reject
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        ISSUE        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  btn_raw;
    logic [3:0]  dir_mask;
    logic [1:0]  dir_enc;
    logic        any_btn;
    logic        one_btn;
    logic        other_btn;

    // Bit index equals the direction code: 0=L, 1=R, 2=U, 3=D.
    assign btn_raw = {btn_D, btn_U, btn_R, btn_L};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign any_btn   = |sync2;
    assign one_btn   = any_btn && ((sync2 & (sync2 - 4'd1)) == 4'd0);
    assign dir_mask  = 4'd1 << move_dir;
    assign other_btn = |(sync2 & ~dir_mask);

    always_comb begin
        dir_enc = 2'd0;
        case (sync2)
            4'b0010: dir_enc = 2'd1;
            4'b0100: dir_enc = 2'd2;
            4'b1000: dir_enc = 2'd3;
            default: dir_enc = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_RELEASE;
            cnt        <= 16'd0;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            move_count <= 16'd0;
            reject     <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_btn) begin
                        move_dir <= dir_enc;
                        cnt      <= 16'd0;
                        state    <= DEBOUNCE;
                    end else if (any_btn) begin
                        reject <= 1'b1;
                        cnt    <= 16'd0;
                        state  <= WAIT_RELEASE;
                    end
                end
                DEBOUNCE: begin
                    if (other_btn) begin
                        reject <= 1'b1;
                        cnt    <= 16'd0;
                        state  <= WAIT_RELEASE;
                    end else if (sync2 == dir_mask) begin
                        if (cnt == CNT_LAST) begin
                            state      <= ISSUE;
                            move_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (move_ready) begin
                        move_count <= move_count + 16'd1;
                        move_valid <= 1'b0;
                        cnt        <= 16'd0;
                        state      <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    // Any activity restarts the quiet period, so a held button never re-arms.
                    if (any_btn) begin
                        cnt <= 16'd0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state      <= WAIT_RELEASE;
                    cnt        <= 16'd0;
                    move_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Scoreboard bench for btn_move_ctrl: expected moves are queued when a press is driven, popped on move_valid.
module tb_btn_move_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_L;
    logic        btn_R;
    logic        btn_U;
    logic        btn_D;
    logic        move_ready;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic [15:0] move_count;
    logic        reject;

    int          pass_cnt;
    int          total_cnt;
    logic [1:0]  exp_dir_q[$];
    logic [15:0] exp_count;

    btn_move_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_L      (btn_L),
        .btn_R      (btn_R),
        .btn_U      (btn_U),
        .btn_D      (btn_D),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_count (move_count),
        .reject     (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (move_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; btn_L = 0; btn_R = 0; btn_U = 0; btn_D = 0; move_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (move_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", move_valid); else pass_cnt++;
        total_cnt++;
        if (move_dir !== 2'd0) $display("FAIL reset_dir got=%0d exp=0", move_dir); else pass_cnt++;
        total_cnt++;
        if (move_count !== 16'd0) $display("FAIL reset_count got=%h exp=0000", move_count); else pass_cnt++;
        total_cnt++;
        if (reject !== 1'b0) $display("FAIL reset_reject got=%b exp=0", reject); else pass_cnt++;
        exp_count = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (move_valid !== 1'b0) $display("FAIL reset_idle_valid got=%b exp=0", move_valid); else pass_cnt++;
    endtask

    task automatic test_single_r();
        bit         early;
        bit         later;
        logic [1:0] d;
        early = 0; later = 0;
        @(negedge clk);
        btn_R = 1'b1; move_ready = 1'b1;
        exp_dir_q.push_back(2'd1);
        repeat (6) begin
            @(negedge clk);
            if (move_valid === 1'b1) early = 1;
        end
        total_cnt++;
        if (early !== 1'b0) $display("FAIL latency_early got=%b exp=0", early); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (move_valid !== 1'b1) $display("FAIL latency_edge7 got=%b exp=1", move_valid); else pass_cnt++;
        d = exp_dir_q.pop_front();
        exp_count++;
        total_cnt++;
        if (move_dir !== d) $display("FAIL single_dir got=%0d exp=%0d", move_dir, d); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (move_valid !== 1'b0) $display("FAIL single_one_cycle got=%b exp=0", move_valid); else pass_cnt++;
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL single_count got=%h exp=%h", move_count, exp_count); else pass_cnt++;
        repeat (12) begin
            @(negedge clk);
            if (move_valid === 1'b1) later = 1;
        end
        total_cnt++;
        if (later !== 1'b0) $display("FAIL single_hold_repeat got=%b exp=0", later); else pass_cnt++;
        btn_R = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch();
        bit saw_valid;
        bit saw_reject;
        saw_valid = 0; saw_reject = 0;
        move_ready = 1'b1;
        @(negedge clk);
        btn_U = 1'b1;
        repeat (3) @(negedge clk);
        btn_U = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (move_valid === 1'b1) saw_valid = 1;
            if (reject === 1'b1) saw_reject = 1;
        end
        total_cnt++;
        if (saw_valid !== 1'b0) $display("FAIL glitch_valid got=%b exp=0", saw_valid); else pass_cnt++;
        total_cnt++;
        if (saw_reject !== 1'b0) $display("FAIL glitch_reject got=%b exp=0", saw_reject); else pass_cnt++;
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL glitch_count got=%h exp=%h", move_count, exp_count); else pass_cnt++;
    endtask

    task automatic test_multi_reject();
        int         rej_n;
        int         rej_edge;
        bit         saw_valid;
        bit         ok;
        logic [1:0] d;
        rej_n = 0; rej_edge = 0; saw_valid = 0;
        move_ready = 1'b1;
        @(negedge clk);
        btn_L = 1'b1; btn_D = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (reject === 1'b1) begin
                rej_n++;
                rej_edge = i;
            end
            if (move_valid === 1'b1) saw_valid = 1;
        end
        total_cnt++;
        if (rej_n !== 1) $display("FAIL reject_pulses got=%0d exp=1", rej_n); else pass_cnt++;
        total_cnt++;
        if (rej_edge !== 3) $display("FAIL reject_edge got=%0d exp=3", rej_edge); else pass_cnt++;
        total_cnt++;
        if (saw_valid !== 1'b0) $display("FAIL reject_valid got=%b exp=0", saw_valid); else pass_cnt++;
        btn_L = 1'b0; btn_D = 1'b0;
        repeat (8) @(negedge clk);
        btn_D = 1'b1;
        exp_dir_q.push_back(2'd3);
        wait_valid(20, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL reject_recover_timeout got=%b exp=1", ok); else pass_cnt++;
        d = exp_dir_q.pop_front();
        exp_count++;
        total_cnt++;
        if (move_dir !== d) $display("FAIL reject_recover_dir got=%0d exp=%0d", move_dir, d); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL reject_recover_count got=%h exp=%h", move_count, exp_count); else pass_cnt++;
        btn_D = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit         ok;
        bit         stable;
        bit         again;
        logic [1:0] d;
        stable = 1; again = 0;
        move_ready = 1'b0;
        @(negedge clk);
        btn_D = 1'b1;
        exp_dir_q.push_back(2'd3);
        wait_valid(20, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL bp_timeout got=%b exp=1", ok); else pass_cnt++;
        d = exp_dir_q.pop_front();
        total_cnt++;
        if (move_dir !== d) $display("FAIL bp_dir got=%0d exp=%0d", move_dir, d); else pass_cnt++;
        repeat (10) begin
            @(negedge clk);
            if (move_valid !== 1'b1 || move_dir !== d) stable = 0;
        end
        total_cnt++;
        if (stable !== 1'b1) $display("FAIL bp_stable got=%b exp=1", stable); else pass_cnt++;
        move_ready = 1'b1;
        exp_count++;
        @(negedge clk);
        total_cnt++;
        if (move_valid !== 1'b0) $display("FAIL bp_drop got=%b exp=0", move_valid); else pass_cnt++;
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL bp_count got=%h exp=%h", move_count, exp_count); else pass_cnt++;
        repeat (20) begin
            @(negedge clk);
            if (move_valid === 1'b1) again = 1;
        end
        total_cnt++;
        if (again !== 1'b0) $display("FAIL bp_second_move got=%b exp=0", again); else pass_cnt++;
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL bp_count_after_hold got=%h exp=%h", move_count, exp_count); else pass_cnt++;
        btn_D = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_hold();
        bit         ok;
        bit         saw_valid;
        logic [1:0] d;
        saw_valid = 0;
        move_ready = 1'b0;
        @(negedge clk);
        btn_L = 1'b1;
        wait_valid(20, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL rsthold_issue_timeout got=%b exp=1", ok); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        exp_count = 16'd0;
        total_cnt++;
        if (move_valid !== 1'b0) $display("FAIL rsthold_async_valid got=%b exp=0", move_valid); else pass_cnt++;
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL rsthold_async_count got=%h exp=%h", move_count, exp_count); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        move_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (move_valid === 1'b1) saw_valid = 1;
        end
        total_cnt++;
        if (saw_valid !== 1'b0) $display("FAIL rsthold_no_move got=%b exp=0", saw_valid); else pass_cnt++;
        btn_L = 1'b0;
        repeat (8) @(negedge clk);
        btn_L = 1'b1;
        exp_dir_q.push_back(2'd0);
        wait_valid(20, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL rsthold_repress_timeout got=%b exp=1", ok); else pass_cnt++;
        d = exp_dir_q.pop_front();
        exp_count++;
        total_cnt++;
        if (move_dir !== d) $display("FAIL rsthold_dir got=%0d exp=%0d", move_dir, d); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL rsthold_count got=%h exp=%h", move_count, exp_count); else pass_cnt++;
        btn_L = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_wrap();
        bit         ok;
        logic [1:0] d;
        @(negedge clk);
        force dut.move_count = 16'hFFFF;
        #1;
        release dut.move_count;
        exp_count = 16'hFFFF;
        move_ready = 1'b1;
        @(negedge clk);
        btn_R = 1'b1;
        exp_dir_q.push_back(2'd1);
        wait_valid(20, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL wrap_timeout got=%b exp=1", ok); else pass_cnt++;
        d = exp_dir_q.pop_front();
        exp_count++;
        total_cnt++;
        if (move_dir !== d) $display("FAIL wrap_dir got=%0d exp=%0d", move_dir, d); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (move_count !== exp_count) $display("FAIL wrap_count got=%h exp=%h", move_count, exp_count); else pass_cnt++;
        btn_R = 1'b0;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (exp_dir_q.size() !== 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_dir_q.size()); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        exp_count = 16'd0;
        test_reset();
        test_single_r();
        test_glitch();
        test_multi_reject();
        test_backpressure();
        test_reset_hold();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
